systolic_skew_feeder: RTL and testbench
=======================================

// Module: systolic_skew_feeder
// PURPOSE
//  Downstream consumer of the matrix-slice generators (MtrxA/MtrxB slice streams).
//  Buffers one NxN tile of A and one NxN tile of B, each arriving row-major, one element per beat.
//  Then replays both tiles into the systolic array edges with diagonal skew:
//  row i of A and column j of B are each delayed i (resp. j) steps.
//  Applies valid/ready back-pressure on both input streams and accepts a stall from the array.
// PARAMETERS
//  N      8  SYSTOLIC_UNIT_NUM; array dimension; tile = N*N elements (N>=2)
//  DW     8  SYSTOLIC_DATA_WIDTH; bits per element
// PORTS
//  s_clk              in   1     clock
//  s_rst              in   1     async reset, active-high
//  MtrxA_slice_valid  in   1     A element valid
//  MtrxA_slice_data   in   DW    A element, row-major order A[i][k]
//  MtrxA_slice_done   in   1     marks the last A beat of a tile
//  MtrxA_slice_ready  out  1     feeder accepts A element
//  MtrxB_slice_valid  in   1     B element valid
//  MtrxB_slice_data   in   DW    B element, row-major order B[k][j]
//  MtrxB_slice_done   in   1     marks the last B beat of a tile
//  MtrxB_slice_ready  out  1     feeder accepts B element
//  feed_ready         in   1     array accepts a skew step; low = stall
//  feed_valid         out  1     skew step valid
//  feed_a_row         out  N*DW  lane i = [i*DW +: DW], drives array row i
//  feed_b_col         out  N*DW  lane j = [j*DW +: DW], drives array column j
//  feed_first         out  1     high on step t=0
//  feed_last          out  1     high on step t=2N-2
//  tile_done          out  1     one-cycle pulse after the last step is accepted
//  err_len            out  1     sticky done/length mismatch flag
// BEHAVIOUR
//  Reset (async): state=LOAD; a_cnt=b_cnt=0; t=0; tile_done=0; err_len=0.
//   While s_rst=1, both readies=0. feed_valid=0 and all feed data/flags=0.
//   Buffers are not reset; they are always overwritten before use.
//  Counters: a_cnt, b_cnt are $clog2(N*N+1) bits; t is $clog2(2N) bits.
//  State LOAD:
//   - MtrxA_slice_ready = (a_cnt != N*N). Combinational from registered state.
//   - Handshake (valid & ready): bufA[a_cnt] <= data; a_cnt++.
//     Element index idx maps to row idx/N, col idx%N. B handled identically and independently.
//   - A and B may finish in either order; the finished stream holds ready low and waits.
//   - When both counts reach N*N, including the same-edge case: state <= FEED, t <= 0.
//  done checking: on each handshake, done must equal (cnt == N*N-1). Any mismatch sets err_len.
//   err_len stays set until reset. The tile still closes on count N*N. done without a handshake is ignored.
//  State FEED:
//   - Both readies = 0.
//   - feed_valid = 1. Outputs are combinational from t and buffers; the first step appears the cycle after entry.
//   - lane i of feed_a_row = A[i][t-i] if 0 <= t-i <= N-1, else 0.
//   - lane j of feed_b_col = B[t-j][j] if 0 <= t-j <= N-1, else 0.
//   - feed_valid & feed_ready: t++. When feed_ready=0: t, data and flags hold unchanged.
//   - Exactly 2N-1 accepted steps per tile.
//   - On acceptance at t=2N-2: state <= LOAD; a_cnt=b_cnt=0; tile_done <= 1 for one cycle.
//     Readies reassert in that same cycle.
//  Outside FEED: feed_valid=0, feed data/flags=0.
//  Reset mid-operation aborts the partial load or feed; the partial tile is discarded.
//  Throughput: a new tile load overlaps nothing; load takes >= N*N cycles, feed takes >= 2N-1 cycles.
// TESTING
//  1. N=4, A=0..15, B=16..31 continuous, feed_ready=1 -> 7 steps.
//     t=0: a={0,0,0,0}, b lane0=16.
//     t=3: a lanes0..3={3,6,9,12}, b lanes0..3={28,25,22,19}.
//     t=6: a lane3=15, b lane3=31. feed_last at t=6; tile_done 1 cycle later.
//  2. A sends 16 beats; B starts 20 cycles later -> A ready low after beat 16.
//     feed_valid rises the cycle after B's 16th handshake.
//  3. feed_ready low for 3 cycles at t=2 -> t=2 data held for all 3 cycles.
//     Exactly 7 accepted steps; values match scenario 1.
//  4. MtrxA_slice_done on beat 10 and not on beat 16 -> err_len=1 and stays 1.
//     Tile still closes at 16 and feeds normally.
//  5. s_rst pulse after 5 A beats -> readies=0 during reset, a_cnt=0 after.
//     The next 16+16 beats give scenario-1 output.
//  6. Two tiles back-to-back, generators always valid -> readies low during FEED.
//     No element is lost or duplicated; tile 2 output is correct.

Source files
------------

// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_skew_feeder_if : A/B slice streams and skewed array feed bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface systolic_skew_feeder_if #(
  parameter int N  = 8,
  parameter int DW = 8
);
  logic            MtrxA_slice_valid;
  logic [DW-1:0]   MtrxA_slice_data;
  logic            MtrxA_slice_done;
  logic            MtrxA_slice_ready;
  logic            MtrxB_slice_valid;
  logic [DW-1:0]   MtrxB_slice_data;
  logic            MtrxB_slice_done;
  logic            MtrxB_slice_ready;
  logic            feed_ready;
  logic            feed_valid;
  logic [N*DW-1:0] feed_a_row;
  logic [N*DW-1:0] feed_b_col;
  logic            feed_first;
  logic            feed_last;
  logic            tile_done;
  logic            err_len;

  modport master (
    output MtrxA_slice_valid, MtrxA_slice_data, MtrxA_slice_done,
    output MtrxB_slice_valid, MtrxB_slice_data, MtrxB_slice_done,
    output feed_ready,
    input  MtrxA_slice_ready, MtrxB_slice_ready,
    input  feed_valid, feed_a_row, feed_b_col, feed_first, feed_last,
    input  tile_done, err_len
  );

  modport slave (
    input  MtrxA_slice_valid, MtrxA_slice_data, MtrxA_slice_done,
    input  MtrxB_slice_valid, MtrxB_slice_data, MtrxB_slice_done,
    input  feed_ready,
    output MtrxA_slice_ready, MtrxB_slice_ready,
    output feed_valid, feed_a_row, feed_b_col, feed_first, feed_last,
    output tile_done, err_len
  );
endinterface
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_skew_feeder : buffers one NxN tile of A and B, replays them skewed
// Rev 1.0
// ---------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int N  = 8,
  parameter int DW = 8
) (
  input  wire logic              s_clk,
  input  wire logic              s_rst,
  systolic_skew_feeder_if.slave  bus_io
);
  localparam int NN = N * N;
  localparam int CW = $clog2(NN + 1);
  localparam int TW = $clog2(2 * N);
  localparam int IW = $clog2(NN);
  localparam logic [CW-1:0] C_FULL      = CW'(NN);
  localparam logic [CW-1:0] C_LAST_BEAT = CW'(NN - 1);
  localparam logic [TW-1:0] C_LAST_STEP = TW'(2 * N - 2);

  typedef enum logic [0:0] {ST_LOAD = 1'b0, ST_FEED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [TW-1:0]   t_q, t_d;
  logic            tile_done_q, tile_done_d;
  logic            err_len_q, err_len_d;
  logic [DW-1:0]   bufa_q [NN];
  logic [DW-1:0]   bufb_q [NN];

  logic            a_rdy, b_rdy, a_hs, b_hs, feeding;
  logic [N*DW-1:0] a_row, b_col;

  // Readies are forced low while reset is asserted, not just after it.
  assign a_rdy   = ~s_rst & (state_q == ST_LOAD) & (a_cnt_q != C_FULL);
  assign b_rdy   = ~s_rst & (state_q == ST_LOAD) & (b_cnt_q != C_FULL);
  assign a_hs    = a_rdy & bus_io.MtrxA_slice_valid;
  assign b_hs    = b_rdy & bus_io.MtrxB_slice_valid;
  assign feeding = (state_q == ST_FEED);

  always_ff @(posedge s_clk) begin
    if (a_hs) bufa_q[a_cnt_q[IW-1:0]] <= bus_io.MtrxA_slice_data;
    if (b_hs) bufb_q[b_cnt_q[IW-1:0]] <= bus_io.MtrxB_slice_data;
  end

  // Lane i shows the element on the i-th anti-diagonal offset: A[i][t-i], B[t-j][j].
  for (genvar i = 0; i < N; i++) begin : g_lane
    int k_w;
    always_comb begin
      k_w = int'(t_q) - i;
      a_row[i*DW +: DW] = '0;
      b_col[i*DW +: DW] = '0;
      if (feeding && k_w >= 0 && k_w < N) begin
        a_row[i*DW +: DW] = bufa_q[IW'(i * N + k_w)];
        b_col[i*DW +: DW] = bufb_q[IW'(k_w * N + i)];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    a_cnt_d     = a_cnt_q;
    b_cnt_d     = b_cnt_q;
    t_d         = t_q;
    tile_done_d = 1'b0;
    err_len_d   = err_len_q;
    case (state_q)
      ST_LOAD: begin
        if (a_hs) begin
          a_cnt_d = a_cnt_q + 1'b1;
          if (bus_io.MtrxA_slice_done != (a_cnt_q == C_LAST_BEAT)) err_len_d = 1'b1;
        end
        if (b_hs) begin
          b_cnt_d = b_cnt_q + 1'b1;
          if (bus_io.MtrxB_slice_done != (b_cnt_q == C_LAST_BEAT)) err_len_d = 1'b1;
        end
        if (a_cnt_d == C_FULL && b_cnt_d == C_FULL) begin
          state_d = ST_FEED;
          t_d     = '0;
        end
      end
      ST_FEED: begin
        if (bus_io.feed_ready) begin
          if (t_q == C_LAST_STEP) begin
            state_d     = ST_LOAD;
            a_cnt_d     = '0;
            b_cnt_d     = '0;
            t_d         = '0;
            tile_done_d = 1'b1;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q     <= ST_LOAD;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      t_q         <= '0;
      tile_done_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      t_q         <= t_d;
      tile_done_q <= tile_done_d;
      err_len_q   <= err_len_d;
    end
  end

  assign bus_io.MtrxA_slice_ready = a_rdy;
  assign bus_io.MtrxB_slice_ready = b_rdy;
  assign bus_io.feed_valid        = feeding;
  assign bus_io.feed_a_row        = a_row;
  assign bus_io.feed_b_col        = b_col;
  assign bus_io.feed_first        = feeding && (t_q == '0);
  assign bus_io.feed_last         = feeding && (t_q == C_LAST_STEP);
  assign bus_io.tile_done         = tile_done_q;
  assign bus_io.err_len           = err_len_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_systolic_skew_feeder : randomized stimulus against a matrix-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_systolic_skew_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int NN = N * N;

  logic s_clk = 1'b0;
  logic s_rst = 1'b1;
  systolic_skew_feeder_if #(.N(N), .DW(DW)) bus ();

  systolic_skew_feeder #(.N(N), .DW(DW)) dut (
    .s_clk  (s_clk),
    .s_rst  (s_rst),
    .bus_io (bus)
  );

  always #5 s_clk = ~s_clk;

  int checks = 0;
  int failures = 0;

  // Matrix-level model: tiles captured from the accepted beats, step index k.
  logic [DW-1:0] ma [NN];
  logic [DW-1:0] mb [NN];
  int acnt = 0, bcnt = 0, mk = 0;
  bit in_feed = 0, done_pend = 0, merr = 0;
  int acc_steps = 0, tiles_cnt = 0;
  bit pin_en = 0;
  int fr_mode = 0;
  bit stall_done = 0;
  int stall_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tb_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  function automatic logic [N*DW-1:0] exp_a_row(input int t);
    logic [N*DW-1:0] r = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) r[i*DW +: DW] = ma[i*N + t - i];
    return r;
  endfunction

  function automatic logic [N*DW-1:0] exp_b_col(input int t);
    logic [N*DW-1:0] r = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) r[j*DW +: DW] = mb[(t - j)*N + j];
    return r;
  endfunction

  // Compare process: checks every cycle, then advances the model by one edge.
  initial begin
    forever begin
      @(negedge s_clk);
      if (s_rst) begin
        chk("rst_rdyA", bus.MtrxA_slice_ready, 0);
        chk("rst_rdyB", bus.MtrxB_slice_ready, 0);
        chk("rst_fvalid", bus.feed_valid, 0);
        chk("rst_a_row", bus.feed_a_row, 0);
        acnt = 0; bcnt = 0; mk = 0;
        in_feed = 0; done_pend = 0; merr = 0;
      end else begin
        chk("rdyA", bus.MtrxA_slice_ready, !in_feed && acnt < NN);
        chk("rdyB", bus.MtrxB_slice_ready, !in_feed && bcnt < NN);
        chk("fvalid", bus.feed_valid, in_feed);
        chk("a_row", bus.feed_a_row, in_feed ? exp_a_row(mk) : '0);
        chk("b_col", bus.feed_b_col, in_feed ? exp_b_col(mk) : '0);
        chk("first", bus.feed_first, in_feed && mk == 0);
        chk("last", bus.feed_last, in_feed && mk == 2*N-2);
        chk("tile_done", bus.tile_done, done_pend);
        chk("err_len", bus.err_len, merr);
        if (bus.tile_done) tiles_cnt++;
        if (pin_en && in_feed) begin
          if (mk == 0) begin
            chk("pin_t0_a", bus.feed_a_row, 64'h0000_0000);
            chk("pin_t0_b", bus.feed_b_col, 64'h0000_0010);
          end
          if (mk == 3) begin
            chk("pin_t3_a", bus.feed_a_row, 64'h0C09_0603);
            chk("pin_t3_b", bus.feed_b_col, 64'h1316_191C);
          end
          if (mk == 6) begin
            chk("pin_t6_a", bus.feed_a_row, 64'h0F00_0000);
            chk("pin_t6_b", bus.feed_b_col, 64'h1F00_0000);
          end
        end
        done_pend = 0;
        if (in_feed) begin
          if (bus.feed_ready) begin
            acc_steps++;
            mk++;
            if (mk == 2*N-1) begin
              in_feed = 0; acnt = 0; bcnt = 0; done_pend = 1;
            end
          end
        end else begin
          if (bus.MtrxA_slice_valid && acnt < NN) begin
            if (bus.MtrxA_slice_done != (acnt == NN-1)) merr = 1;
            ma[acnt] = bus.MtrxA_slice_data;
            acnt++;
          end
          if (bus.MtrxB_slice_valid && bcnt < NN) begin
            if (bus.MtrxB_slice_done != (bcnt == NN-1)) merr = 1;
            mb[bcnt] = bus.MtrxB_slice_data;
            bcnt++;
          end
          if (acnt == NN && bcnt == NN) begin
            in_feed = 1; mk = 0;
          end
        end
      end
    end
  end

  // feed_ready driver: 0 = always ready, 1 = random, 2 = one 3-cycle stall at t=2.
  initial begin
    bus.feed_ready = 1'b1;
    forever begin
      @(posedge s_clk);
      #1;
      case (fr_mode)
        1: bus.feed_ready = 1'($urandom_range(0, 1));
        2: begin
          if (!stall_done && in_feed && mk == 2) begin
            stall_done = 1;
            stall_left = 3;
          end
          if (stall_left > 0) begin
            bus.feed_ready = 1'b0;
            stall_left--;
          end else begin
            bus.feed_ready = 1'b1;
          end
        end
        default: bus.feed_ready = 1'b1;
      endcase
    end
  end

  // sel=0 drives A, sel=1 drives B. base<0 gives random data.
  task automatic send(input bit sel, input int nbeats, input int base,
                      input int done_idx, input int gapmax);
    for (int idx = 0; idx < nbeats; idx++) begin
      int to;
      logic [DW-1:0] d;
      d = (base < 0) ? DW'($urandom) : DW'(base + idx);
      repeat ($urandom_range(0, gapmax)) begin
        if (sel) bus.MtrxB_slice_valid = 1'b0; else bus.MtrxA_slice_valid = 1'b0;
        @(posedge s_clk); #1;
      end
      if (sel) begin
        bus.MtrxB_slice_valid = 1'b1; bus.MtrxB_slice_data = d;
        bus.MtrxB_slice_done = (idx == done_idx);
      end else begin
        bus.MtrxA_slice_valid = 1'b1; bus.MtrxA_slice_data = d;
        bus.MtrxA_slice_done = (idx == done_idx);
      end
      to = 0;
      forever begin
        @(negedge s_clk);
        if (sel ? bus.MtrxB_slice_ready : bus.MtrxA_slice_ready) break;
        to++;
        if (to > 2000) begin
          tb_fail(sel ? "send_b" : "send_a");
          break;
        end
      end
      @(posedge s_clk); #1;
    end
    if (sel) begin
      bus.MtrxB_slice_valid = 1'b0; bus.MtrxB_slice_done = 1'b0;
    end else begin
      bus.MtrxA_slice_valid = 1'b0; bus.MtrxA_slice_done = 1'b0;
    end
  endtask

  task automatic wait_tiles(input int target);
    int to = 0;
    while (tiles_cnt < target) begin
      @(negedge s_clk);
      to++;
      if (to > 3000) begin
        tb_fail("wait_tiles");
        break;
      end
    end
    @(posedge s_clk); #1;
  endtask

  task automatic std_tile(input int gapmax);
    int t0 = tiles_cnt;
    fork
      send(0, NN, 0, NN-1, gapmax);
      send(1, NN, 16, NN-1, gapmax);
    join
    wait_tiles(t0 + 1);
  endtask

  initial begin
    int t0, s0;
    bus.MtrxA_slice_valid = 0; bus.MtrxA_slice_data = 0; bus.MtrxA_slice_done = 0;
    bus.MtrxB_slice_valid = 0; bus.MtrxB_slice_data = 0; bus.MtrxB_slice_done = 0;
    repeat (3) @(posedge s_clk);
    @(negedge s_clk);
    chk("reset_err", bus.err_len, 0);
    chk("reset_tdone", bus.tile_done, 0);
    @(posedge s_clk); #1;
    s_rst = 1'b0;
    @(negedge s_clk);
    chk("post_rst_rdyA", bus.MtrxA_slice_ready, 1);
    @(posedge s_clk); #1;

    // 1: continuous A=0..15, B=16..31
    pin_en = 1; fr_mode = 0;
    std_tile(0);

    // 2: B starts 20 cycles after A
    t0 = tiles_cnt;
    fork
      begin
        send(0, NN, 0, NN-1, 0);
        @(negedge s_clk);
        chk("s2_rdyA_low", bus.MtrxA_slice_ready, 0);
      end
      begin
        repeat (20) @(posedge s_clk);
        #1;
        send(1, NN, 16, NN-1, 0);
      end
    join
    wait_tiles(t0 + 1);

    // 3: three-cycle stall at t=2
    fr_mode = 2; stall_done = 0; s0 = acc_steps;
    std_tile(0);
    chk("s3_steps", acc_steps - s0, 7);
    fr_mode = 0;
    pin_en = 0;

    // 4: done on beat 10 instead of beat 16
    t0 = tiles_cnt;
    fork
      send(0, NN, -1, 9, 1);
      send(1, NN, -1, NN-1, 1);
    join
    wait_tiles(t0 + 1);
    chk("s4_err_set", bus.err_len, 1);
    repeat (3) @(posedge s_clk);
    #1;
    chk("s4_err_sticky", bus.err_len, 1);

    // 5: reset after 5 A beats aborts the partial tile
    send(0, 5, -1, -1, 0);
    s_rst = 1'b1;
    @(negedge s_clk);
    chk("s5_rdyA_rst", bus.MtrxA_slice_ready, 0);
    chk("s5_rdyB_rst", bus.MtrxB_slice_ready, 0);
    @(posedge s_clk); #1;
    s_rst = 1'b0;
    pin_en = 1;
    std_tile(0);
    pin_en = 0;

    // 6: two tiles back-to-back, generators always valid, random stalls
    fr_mode = 1;
    t0 = tiles_cnt;
    fork
      begin send(0, NN, -1, NN-1, 0); send(0, NN, -1, NN-1, 0); end
      begin send(1, NN, -1, NN-1, 0); send(1, NN, -1, NN-1, 0); end
    join
    wait_tiles(t0 + 2);

    // Random tiles with gaps and random feed back-pressure
    for (int r = 0; r < 6; r++) begin
      t0 = tiles_cnt;
      fork
        send(0, NN, -1, NN-1, 3);
        send(1, NN, -1, NN-1, 3);
      join
      wait_tiles(t0 + 1);
    end
    fr_mode = 0;
    repeat (4) @(posedge s_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
